// File: rtl/cmp_minmax_tracker.sv
// Per-frame min/max tracker for a stream of 4-bit samples, built on two cmp4b comparators.
// Results are held on a valid/ready output port until the consumer takes them.

module cmp4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       eq,
  output logic       lt,
  output logic       gt
);
  assign eq = (a == b);
  assign lt = (a < b);
  assign gt = (a > b);
endmodule

module cmp_minmax_tracker #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_min,
  output logic [3:0] out_max,
  output logic       out_same
);
  localparam int unsigned DATA_W = 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] min_r;
  logic [DATA_W-1:0] max_r;
  logic [DATA_W-1:0] next_min;
  logic [DATA_W-1:0] next_max;
  logic              min_eq, min_lt, min_gt;
  logic              max_eq, max_lt, max_gt;
  logic              accept;

  cmp4b u_cmp_min (.a(in_data), .b(min_r), .eq(min_eq), .lt(min_lt), .gt(min_gt));
  cmp4b u_cmp_max (.a(in_data), .b(max_r), .eq(max_eq), .lt(max_lt), .gt(max_gt));

  // Ready depends only on state, clr and reset, never on in_valid.
  assign in_ready = rst_b & ~clr & (state != HOLD);
  assign accept   = in_valid & in_ready;

  // Running extremes including the sample on the bus; equal samples leave them untouched.
  always_comb begin
    next_min = min_r;
    next_max = max_r;
    case ({min_lt, min_eq, min_gt})
      3'b100:  next_min = in_data;
      default: next_min = min_r;
    endcase
    case ({max_lt, max_eq, max_gt})
      3'b001:  next_max = in_data;
      default: next_max = max_r;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      count     <= '0;
      min_r     <= 4'hF;
      max_r     <= 4'h0;
      out_valid <= 1'b0;
      out_min   <= '0;
      out_max   <= '0;
      out_same  <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            min_r <= in_data;
            max_r <= in_data;
            count <= CNT_W'(1);
            state <= ACC;
          end
        end
        ACC: begin
          if (accept) begin
            min_r <= next_min;
            max_r <= next_max;
            if (count == LAST_CNT) begin
              out_min   <= next_min;
              out_max   <= next_max;
              out_same  <= (next_min == next_max);
              out_valid <= 1'b1;
              count     <= '0;
              state     <= HOLD;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_minmax_tracker.sv
// Scoreboard bench for cmp_minmax_tracker: expected frame results are queued when the
// last sample is accepted and compared while the DUT presents them.

module tb_cmp_minmax_tracker;
  localparam int unsigned FRAME_LEN = 8;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_min;
  logic [3:0] out_max;
  logic       out_same;

  cmp_minmax_tracker #(.FRAME_LEN(FRAME_LEN), .CNT_W(8)) dut (
    .clk(clk), .rst_b(rst_b), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_max(out_max), .out_same(out_same)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mn;
    logic [3:0] mx;
    logic       same;
  } res_t;

  res_t exp_q[$];
  int   frame_q[$];
  logic m_hold = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   n_results = 0;
  int   n_accepted = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check registered outputs, drive inputs, check ready, advance the model.
  task automatic step(input logic v, input logic [3:0] d, input logic ordy, input logic c,
                      output logic acc);
    logic exp_rdy;
    res_t r;
    int   mn, mx;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(m_hold));
    if (m_hold && exp_q.size() > 0) begin
      check("out_min", 32'(out_min), 32'(exp_q[0].mn));
      check("out_max", 32'(out_max), 32'(exp_q[0].mx));
      check("out_same", 32'(out_same), 32'(exp_q[0].same));
    end
    in_valid = v; in_data = d; out_ready = ordy; clr = c;
    #1;
    exp_rdy = !m_hold && !c;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    if (c) begin
      m_hold = 1'b0;
      frame_q.delete();
      exp_q.delete();
    end else if (m_hold) begin
      if (ordy) begin
        m_hold = 1'b0;
        void'(exp_q.pop_front());
        n_results++;
      end
    end else if (v) begin
      frame_q.push_back(int'(d));
      n_accepted++;
      if (frame_q.size() == FRAME_LEN) begin
        mn = 15; mx = 0;
        foreach (frame_q[i]) begin
          if (frame_q[i] < mn) mn = frame_q[i];
          if (frame_q[i] > mx) mx = frame_q[i];
        end
        r.mn = 4'(mn); r.mx = 4'(mx); r.same = (mn == mx);
        exp_q.push_back(r);
        m_hold = 1'b1;
        frame_q.delete();
      end
    end
  endtask

  task automatic send(input logic [3:0] d, input logic ordy);
    logic acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, d, ordy, 1'b0, acc);
      if (acc) break;
    end
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, ordy, 1'b0, acc);
  endtask

  // Reset asserted away from any clock edge; outputs must drop at once.
  task automatic async_reset();
    @(negedge clk);
    #2;
    in_valid = 1'b0;
    rst_b = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_min", 32'(out_min), 32'd0);
    check("rst_out_max", 32'(out_max), 32'd0);
    check("rst_out_same", 32'(out_same), 32'd0);
    m_hold = 1'b0;
    frame_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_b = 1'b1;
  endtask

  initial begin
    logic acc;
    logic [3:0] t1[8] = '{4'd3, 4'd9, 4'd1, 4'd7, 4'd15, 4'd0, 4'd4, 4'd4};
    int cyc;

    #3;
    check("init_out_valid", 32'(out_valid), 32'd0);
    check("init_in_ready", 32'(in_ready), 32'd0);
    check("init_out_min", 32'(out_min), 32'd0);
    check("init_out_max", 32'(out_max), 32'd0);
    check("init_out_same", 32'(out_same), 32'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;

    // 1: mixed frame, consumer always ready
    foreach (t1[i]) send(t1[i], 1'b1);
    idle(3, 1'b1);
    // 2: all equal
    for (int i = 0; i < 8; i++) send(4'hA, 1'b1);
    idle(3, 1'b1);
    // 3: back-pressure while offering samples that must not be taken
    for (int i = 0; i < 8; i++) send(4'(5 + i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'h0, 1'b0, 1'b0, acc);
    idle(3, 1'b1);
    // 4: gaps on in_valid
    for (int i = 0; i < 8; i++) begin
      send(4'(2 + i), 1'b1);
      idle(2, 1'b1);
    end
    idle(2, 1'b1);
    // 5: abort a partial frame, offered sample in the clr cycle is dropped
    send(4'h0, 1'b1); send(4'hF, 1'b1); send(4'h3, 1'b1); send(4'h0, 1'b1);
    step(1'b1, 4'h0, 1'b1, 1'b1, acc);
    check("clr_accept", 32'(acc), 32'd0);
    for (int i = 0; i < 8; i++) send((i == 5) ? 4'hE : 4'h1, 1'b1);
    idle(3, 1'b1);
    // 6: reset mid-frame, then a clean frame
    send(4'h0, 1'b1); send(4'hF, 1'b1); send(4'h3, 1'b1);
    async_reset();
    for (int i = 0; i < 8; i++) send(4'(6 + i), 1'b1);
    idle(3, 1'b1);
    check("directed_results", 32'(n_results), 32'd6);
    // reset while a result is pending
    for (int i = 0; i < 8; i++) send(4'(i), 1'b0);
    idle(2, 1'b0);
    async_reset();
    idle(2, 1'b1);

    // random traffic
    n_accepted = 0;
    cyc = 0;
    while (n_accepted < 1000 && cyc < 8000) begin
      step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 99) == 0, acc);
      cyc++;
    end
    check("random_accepts", 32'(n_accepted >= 1000), 32'd1);
    idle(4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
